mips_ex_stage: RTL and testbench

MIPS_EX_STAGE -- requirements
Module: mips_ex_stage

---
 rtl/mips_ex_stage.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_mips_ex_stage.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_ex_stage.sv
// rtl/mips_ex_stage.sv - MIPS execute stage: decode, ALU and EX/MEM pipeline register
//
// Purpose:
//    Decodes one 32-bit MIPS instruction combinationally.
//    Selects the ALU operands and operation, and computes the branch target.
//    Registers the result together with the control bits into the EX/MEM stage.
//
// Ports:
//    clk               in   1   rising-edge clock
//    rst               in   1   synchronous active-low reset (0 = reset)
//    flush             in   1   load a bubble into the output register
//    instr             in  32   instruction word
//    pc_plus4          in  32   instruction address + 4
//    rs_data           in  32   register rs value
//    rt_data           in  32   register rt value
//    jump              out  1   combinational, 1 for op 0x02 (j)
//    me_alu_out        out 32   registered ALU result
//    me_wr_reg         out  5   registered destination register
//    me_store_data     out 32   registered rt_data
//    me_branch_target  out 32   registered pc_plus4 + (sext(imm) << 2)
//    me_mem2reg        out  1   registered load-select
//    me_regwr          out  1   registered register write enable
//    me_memwr          out  1   registered memory write enable
//    me_zero           out  1   registered ALU zero flag
//    me_branch         out  2   registered branch type (00 none, 01 beq, 10 bne)

module mips_ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [31:0] instr,
   input  logic [31:0] pc_plus4,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic        jump,
   output logic [31:0] me_alu_out,
   output logic [4:0]  me_wr_reg,
   output logic [31:0] me_store_data,
   output logic [31:0] me_branch_target,
   output logic        me_mem2reg,
   output logic        me_regwr,
   output logic        me_memwr,
   output logic        me_zero,
   output logic [1:0]  me_branch
);

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10
   } alu_op_t;

   // Instruction fields
   logic [5:0]  op;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [15:0] imm;
   logic [31:0] imm_sext;
   logic [31:0] imm_zext;

   assign op       = instr[31:26];
   assign rs       = instr[25:21];
   assign rt       = instr[20:16];
   assign rd       = instr[15:11];
   assign shamt    = instr[10:6];
   assign funct    = instr[5:0];
   assign imm      = instr[15:0];
   assign imm_sext = {{16{imm[15]}}, imm};
   assign imm_zext = {16'h0000, imm};

   assign jump = (op == 6'h02);

   // Decode outputs
   alu_op_t     alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [4:0]  dec_wr_reg;
   logic        dec_regwr;
   logic        dec_mem2reg;
   logic        dec_memwr;
   logic [1:0]  dec_branch;

   // Anything not matched below (including j) falls through as a bubble:
   // no write, no store, no branch, but the ALU still runs on rs/rt.
   always_comb begin
      alu_op      = ALU_ADD;
      alu_a       = rs_data;
      alu_b       = rt_data;
      dec_wr_reg  = 5'd0;
      dec_regwr   = 1'b0;
      dec_mem2reg = 1'b0;
      dec_memwr   = 1'b0;
      dec_branch  = 2'b00;

      case (op)
         6'h00: begin
            case (funct)
               6'h20, 6'h21: begin
                  alu_op     = ALU_ADD;
                  dec_regwr  = 1'b1;
                  dec_wr_reg = rd;
               end
               6'h22, 6'h23: begin
                  alu_op     = ALU_SUB;
                  dec_regwr  = 1'b1;
                  dec_wr_reg = rd;
               end
               6'h24: begin
                  alu_op     = ALU_AND;
                  dec_regwr  = 1'b1;
                  dec_wr_reg = rd;
               end
               6'h25: begin
                  alu_op     = ALU_OR;
                  dec_regwr  = 1'b1;
                  dec_wr_reg = rd;
               end
               6'h26: begin
                  alu_op     = ALU_XOR;
                  dec_regwr  = 1'b1;
                  dec_wr_reg = rd;
               end
               6'h27: begin
                  alu_op     = ALU_NOR;
                  dec_regwr  = 1'b1;
                  dec_wr_reg = rd;
               end
               6'h2A: begin
                  alu_op     = ALU_SLT;
                  dec_regwr  = 1'b1;
                  dec_wr_reg = rd;
               end
               6'h2B: begin
                  alu_op     = ALU_SLTU;
                  dec_regwr  = 1'b1;
                  dec_wr_reg = rd;
               end
               // Shifts take the amount from shamt via operand A.
               6'h00: begin
                  alu_op     = ALU_SLL;
                  alu_a      = {27'd0, shamt};
                  dec_regwr  = 1'b1;
                  dec_wr_reg = rd;
               end
               6'h02: begin
                  alu_op     = ALU_SRL;
                  alu_a      = {27'd0, shamt};
                  dec_regwr  = 1'b1;
                  dec_wr_reg = rd;
               end
               6'h03: begin
                  alu_op     = ALU_SRA;
                  alu_a      = {27'd0, shamt};
                  dec_regwr  = 1'b1;
                  dec_wr_reg = rd;
               end
               default: ;
            endcase
         end
         6'h08, 6'h09: begin
            alu_op     = ALU_ADD;
            alu_b      = imm_sext;
            dec_regwr  = 1'b1;
            dec_wr_reg = rt;
         end
         6'h0A: begin
            alu_op     = ALU_SLT;
            alu_b      = imm_sext;
            dec_regwr  = 1'b1;
            dec_wr_reg = rt;
         end
         6'h0B: begin
            alu_op     = ALU_SLTU;
            alu_b      = imm_sext;
            dec_regwr  = 1'b1;
            dec_wr_reg = rt;
         end
         6'h0C: begin
            alu_op     = ALU_AND;
            alu_b      = imm_zext;
            dec_regwr  = 1'b1;
            dec_wr_reg = rt;
         end
         6'h0D: begin
            alu_op     = ALU_OR;
            alu_b      = imm_zext;
            dec_regwr  = 1'b1;
            dec_wr_reg = rt;
         end
         6'h0E: begin
            alu_op     = ALU_XOR;
            alu_b      = imm_zext;
            dec_regwr  = 1'b1;
            dec_wr_reg = rt;
         end
         // lui reuses the shifter: imm << 16.
         6'h0F: begin
            alu_op     = ALU_SLL;
            alu_a      = 32'd16;
            alu_b      = imm_zext;
            dec_regwr  = 1'b1;
            dec_wr_reg = rt;
         end
         6'h23: begin
            alu_op      = ALU_ADD;
            alu_b       = imm_sext;
            dec_regwr   = 1'b1;
            dec_mem2reg = 1'b1;
            dec_wr_reg  = rt;
         end
         6'h2B: begin
            alu_op    = ALU_ADD;
            alu_b     = imm_sext;
            dec_memwr = 1'b1;
         end
         6'h04: begin
            alu_op     = ALU_SUB;
            dec_branch = 2'b01;
         end
         6'h05: begin
            alu_op     = ALU_SUB;
            dec_branch = 2'b10;
         end
         default: ;
      endcase
   end

   // ALU
   logic [31:0] alu_res;
   logic [4:0]  sh;

   assign sh = alu_a[4:0];

   always_comb begin
      alu_res = 32'd0;
      case (alu_op)
         ALU_ADD:  alu_res = alu_a + alu_b;
         ALU_SUB:  alu_res = alu_a - alu_b;
         ALU_AND:  alu_res = alu_a & alu_b;
         ALU_OR:   alu_res = alu_a | alu_b;
         ALU_XOR:  alu_res = alu_a ^ alu_b;
         ALU_NOR:  alu_res = ~(alu_a | alu_b);
         ALU_SLT:  alu_res = {31'd0, ($signed(alu_a) < $signed(alu_b))};
         ALU_SLTU: alu_res = {31'd0, (alu_a < alu_b)};
         ALU_SLL:  alu_res = alu_b << sh;
         ALU_SRL:  alu_res = alu_b >> sh;
         ALU_SRA:  alu_res = $unsigned($signed(alu_b) >>> sh);
         default:  alu_res = 32'd0;
      endcase
   end

   logic [31:0] branch_target;
   assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};

   // EX/MEM register: reset beats flush, flush beats new data.
   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         me_alu_out       <= 32'd0;
         me_wr_reg        <= 5'd0;
         me_store_data    <= 32'd0;
         me_branch_target <= 32'd0;
         me_mem2reg       <= 1'b0;
         me_regwr         <= 1'b0;
         me_memwr         <= 1'b0;
         me_zero          <= 1'b0;
         me_branch        <= 2'b00;
      end else begin
         me_alu_out       <= alu_res;
         me_wr_reg        <= dec_wr_reg;
         me_store_data    <= rt_data;
         me_branch_target <= branch_target;
         me_mem2reg       <= dec_mem2reg;
         me_regwr         <= dec_regwr;
         me_memwr         <= dec_memwr;
         me_zero          <= (alu_res == 32'd0);
         me_branch        <= dec_branch;
      end
   end

endmodule

// File: tb/tb_mips_ex_stage.sv
// tb/tb_mips_ex_stage.sv - self-checking bench for mips_ex_stage

module tb_mips_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [31:0] instr;
   logic [31:0] pc_plus4;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        jump;
   logic [31:0] me_alu_out;
   logic [4:0]  me_wr_reg;
   logic [31:0] me_store_data;
   logic [31:0] me_branch_target;
   logic        me_mem2reg;
   logic        me_regwr;
   logic        me_memwr;
   logic        me_zero;
   logic [1:0]  me_branch;

   always #5 clk = ~clk;

   mips_ex_stage dut (
      .clk              (clk),
      .rst              (rst),
      .flush            (flush),
      .instr            (instr),
      .pc_plus4         (pc_plus4),
      .rs_data          (rs_data),
      .rt_data          (rt_data),
      .jump             (jump),
      .me_alu_out       (me_alu_out),
      .me_wr_reg        (me_wr_reg),
      .me_store_data    (me_store_data),
      .me_branch_target (me_branch_target),
      .me_mem2reg       (me_mem2reg),
      .me_regwr         (me_regwr),
      .me_memwr         (me_memwr),
      .me_zero          (me_zero),
      .me_branch        (me_branch)
   );

   typedef struct {
      logic [31:0] alu;
      logic [4:0]  wr_reg;
      logic [31:0] store;
      logic [31:0] target;
      logic        mem2reg;
      logic        regwr;
      logic        memwr;
      logic        zero;
      logic [1:0]  branch;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model used for the randomized sequence
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a_rs,
                                  input logic [31:0] a_rt, input logic [31:0] pc);
      exp_t        e;
      logic [5:0]  o;
      logic [5:0]  f;
      logic [31:0] se;
      logic [31:0] ze;
      o  = ins[31:26];
      f  = ins[5:0];
      se = {{16{ins[15]}}, ins[15:0]};
      ze = {16'h0, ins[15:0]};
      e.alu = a_rs + a_rt; e.wr_reg = 5'd0; e.store = a_rt;
      e.target = pc + (se << 2);
      e.mem2reg = 0; e.regwr = 0; e.memwr = 0; e.branch = 2'b00;
      if (o == 6'h00) begin
         e.regwr = 1'b1; e.wr_reg = ins[15:11];
         case (f)
            6'h20, 6'h21: e.alu = a_rs + a_rt;
            6'h22, 6'h23: e.alu = a_rs - a_rt;
            6'h24: e.alu = a_rs & a_rt;
            6'h25: e.alu = a_rs | a_rt;
            6'h26: e.alu = a_rs ^ a_rt;
            6'h27: e.alu = ~(a_rs | a_rt);
            6'h2A: e.alu = ($signed(a_rs) < $signed(a_rt)) ? 32'd1 : 32'd0;
            6'h2B: e.alu = (a_rs < a_rt) ? 32'd1 : 32'd0;
            6'h00: e.alu = a_rt << ins[10:6];
            6'h02: e.alu = a_rt >> ins[10:6];
            6'h03: e.alu = $unsigned($signed(a_rt) >>> ins[10:6]);
            default: begin e.regwr = 1'b0; e.wr_reg = 5'd0; end
         endcase
      end else begin
         case (o)
            6'h08, 6'h09: begin e.alu = a_rs + se; e.regwr = 1; end
            6'h0A: begin e.alu = ($signed(a_rs) < $signed(se)) ? 32'd1 : 32'd0; e.regwr = 1; end
            6'h0B: begin e.alu = (a_rs < se) ? 32'd1 : 32'd0; e.regwr = 1; end
            6'h0C: begin e.alu = a_rs & ze; e.regwr = 1; end
            6'h0D: begin e.alu = a_rs | ze; e.regwr = 1; end
            6'h0E: begin e.alu = a_rs ^ ze; e.regwr = 1; end
            6'h0F: begin e.alu = {ins[15:0], 16'h0}; e.regwr = 1; end
            6'h23: begin e.alu = a_rs + se; e.regwr = 1; e.mem2reg = 1; end
            6'h2B: begin e.alu = a_rs + se; e.memwr = 1; end
            6'h04: begin e.alu = a_rs - a_rt; e.branch = 2'b01; end
            6'h05: begin e.alu = a_rs - a_rt; e.branch = 2'b10; end
            default: ;
         endcase
         if (e.regwr) e.wr_reg = ins[20:16];
      end
      e.zero = (e.alu == 32'd0);
      return e;
   endfunction

   task automatic drive(input logic [31:0] i, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b);
      instr = i; pc_plus4 = pc; rs_data = a; rt_data = b;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      exp_t g;
      rst = 1'b0; flush = 1'b0;
      drive(32'h00221820, 32'h0, 32'd5, 32'd7);
      e = '{32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
      sb.push_back(e);
      tick();
      tick();
      g = sb.pop_front();
      n_cmp++;
      if ({me_alu_out, me_wr_reg, me_store_data, me_branch_target, me_mem2reg,
           me_regwr, me_memwr, me_zero, me_branch} !==
          {g.alu, g.wr_reg, g.store, g.target, g.mem2reg, g.regwr, g.memwr, g.zero, g.branch}) begin
         n_bad++;
         $display("FAIL reset_all_zero: got alu=%h wr=%h st=%h tg=%h m2r=%b rw=%b mw=%b z=%b br=%b want all 0",
                  me_alu_out, me_wr_reg, me_store_data, me_branch_target, me_mem2reg,
                  me_regwr, me_memwr, me_zero, me_branch);
      end
      rst = 1'b1;
   endtask

   task automatic test_add();
      exp_t g;
      drive(32'h00221820, 32'h0, 32'd5, 32'd7);
      sb.push_back('{32'd12, 5'd3, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00});
      tick();
      g = sb.pop_front();
      n_cmp++; if (me_alu_out !== g.alu) begin n_bad++; $display("FAIL add_alu: got %h want %h", me_alu_out, g.alu); end
      n_cmp++; if (me_wr_reg !== g.wr_reg) begin n_bad++; $display("FAIL add_wr_reg: got %0d want %0d", me_wr_reg, g.wr_reg); end
      n_cmp++; if ({me_regwr, me_memwr, me_zero} !== {g.regwr, g.memwr, g.zero}) begin
         n_bad++; $display("FAIL add_ctrl: got %b want %b", {me_regwr, me_memwr, me_zero}, {g.regwr, g.memwr, g.zero});
      end
   endtask

   task automatic test_lui();
      exp_t g;
      drive(32'h3C011234, 32'h0, 32'hDEAD_BEEF, 32'h0);
      sb.push_back('{32'h12340000, 5'd1, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00});
      tick();
      g = sb.pop_front();
      n_cmp++; if (me_alu_out !== g.alu) begin n_bad++; $display("FAIL lui_alu: got %h want %h", me_alu_out, g.alu); end
      n_cmp++; if ({me_wr_reg, me_regwr} !== {g.wr_reg, g.regwr}) begin
         n_bad++; $display("FAIL lui_wr: got %h want %h", {me_wr_reg, me_regwr}, {g.wr_reg, g.regwr});
      end
   endtask

   task automatic test_branch();
      exp_t g;
      drive(32'h10220003, 32'h100, 32'd9, 32'd9);
      sb.push_back('{32'd0, 5'd0, 32'd9, 32'h10C, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01});
      tick();
      g = sb.pop_front();
      n_cmp++; if (me_branch_target !== g.target) begin n_bad++; $display("FAIL beq_target: got %h want %h", me_branch_target, g.target); end
      n_cmp++; if ({me_branch, me_zero, me_regwr} !== {g.branch, g.zero, g.regwr}) begin
         n_bad++; $display("FAIL beq_ctrl: got %b want %b", {me_branch, me_zero, me_regwr}, {g.branch, g.zero, g.regwr});
      end
      // bne with negative offset: target steps backwards
      drive(32'h1422FFFF, 32'h100, 32'd1, 32'd2);
      sb.push_back('{32'hFFFFFFFF, 5'd0, 32'd2, 32'hFC, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10});
      tick();
      g = sb.pop_front();
      n_cmp++; if (me_branch_target !== g.target) begin n_bad++; $display("FAIL bne_target: got %h want %h", me_branch_target, g.target); end
      n_cmp++; if ({me_branch, me_zero} !== {g.branch, g.zero}) begin
         n_bad++; $display("FAIL bne_ctrl: got %b want %b", {me_branch, me_zero}, {g.branch, g.zero});
      end
   endtask

   task automatic test_mem();
      exp_t g;
      drive(32'hAC220008, 32'h0, 32'h100, 32'hAB);
      sb.push_back('{32'h108, 5'd0, 32'hAB, 32'h20, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00});
      tick();
      g = sb.pop_front();
      n_cmp++; if (me_alu_out !== g.alu) begin n_bad++; $display("FAIL sw_alu: got %h want %h", me_alu_out, g.alu); end
      n_cmp++; if (me_store_data !== g.store) begin n_bad++; $display("FAIL sw_store: got %h want %h", me_store_data, g.store); end
      n_cmp++; if ({me_memwr, me_regwr, me_mem2reg} !== {g.memwr, g.regwr, g.mem2reg}) begin
         n_bad++; $display("FAIL sw_ctrl: got %b want %b", {me_memwr, me_regwr, me_mem2reg}, {g.memwr, g.regwr, g.mem2reg});
      end
      // lw with negative displacement
      drive(32'h8C22FFFC, 32'h0, 32'h200, 32'h0);
      sb.push_back('{32'h1FC, 5'd2, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00});
      tick();
      g = sb.pop_front();
      n_cmp++; if ({me_alu_out, me_wr_reg} !== {g.alu, g.wr_reg}) begin
         n_bad++; $display("FAIL lw_alu_wr: got %h/%0d want %h/%0d", me_alu_out, me_wr_reg, g.alu, g.wr_reg);
      end
      n_cmp++; if ({me_mem2reg, me_regwr, me_memwr} !== {g.mem2reg, g.regwr, g.memwr}) begin
         n_bad++; $display("FAIL lw_ctrl: got %b want %b", {me_mem2reg, me_regwr, me_memwr}, {g.mem2reg, g.regwr, g.memwr});
      end
   endtask

   task automatic test_shift_compare();
      exp_t g;
      drive(32'h00022103, 32'h0, 32'h0, 32'hF0000000);
      sb.push_back('{32'hFF000000, 5'd4, 32'hF0000000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00});
      tick();
      g = sb.pop_front();
      n_cmp++; if ({me_alu_out, me_wr_reg} !== {g.alu, g.wr_reg}) begin
         n_bad++; $display("FAIL sra: got %h/%0d want %h/%0d", me_alu_out, me_wr_reg, g.alu, g.wr_reg);
      end
      drive(32'h0022182A, 32'h0, 32'hFFFFFFFF, 32'd1);
      sb.push_back('{32'd1, 5'd3, 32'd1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00});
      tick();
      g = sb.pop_front();
      n_cmp++; if ({me_alu_out, me_zero} !== {g.alu, g.zero}) begin
         n_bad++; $display("FAIL slt: got %h z=%b want %h z=%b", me_alu_out, me_zero, g.alu, g.zero);
      end
      drive(32'h0022182B, 32'h0, 32'hFFFFFFFF, 32'd1);
      sb.push_back('{32'd0, 5'd3, 32'd1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00});
      tick();
      g = sb.pop_front();
      n_cmp++; if ({me_alu_out, me_zero} !== {g.alu, g.zero}) begin
         n_bad++; $display("FAIL sltu: got %h z=%b want %h z=%b", me_alu_out, me_zero, g.alu, g.zero);
      end
   endtask

   task automatic test_jump_bubble();
      exp_t g;
      drive(32'h08000010, 32'h0, 32'd3, 32'd4);
      #1;
      n_cmp++; if (jump !== 1'b1) begin n_bad++; $display("FAIL jump_comb: got %b want 1", jump); end
      sb.push_back('{32'd7, 5'd0, 32'd4, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
      tick();
      g = sb.pop_front();
      n_cmp++; if ({me_regwr, me_memwr, me_mem2reg, me_branch} !== {g.regwr, g.memwr, g.mem2reg, g.branch}) begin
         n_bad++; $display("FAIL j_bubble: got %b want %b", {me_regwr, me_memwr, me_mem2reg, me_branch}, {g.regwr, g.memwr, g.mem2reg, g.branch});
      end
      n_cmp++; if (me_alu_out !== g.alu) begin n_bad++; $display("FAIL j_alu: got %h want %h", me_alu_out, g.alu); end
      // unlisted R-type funct
      drive(32'h0022183F, 32'h0, 32'd1, 32'd2);
      #1;
      n_cmp++; if (jump !== 1'b0) begin n_bad++; $display("FAIL nojump_comb: got %b want 0", jump); end
      sb.push_back('{32'd3, 5'd0, 32'd2, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
      tick();
      g = sb.pop_front();
      n_cmp++; if ({me_regwr, me_memwr, me_mem2reg, me_branch} !== {g.regwr, g.memwr, g.mem2reg, g.branch}) begin
         n_bad++; $display("FAIL funct_bubble: got %b want %b", {me_regwr, me_memwr, me_mem2reg, me_branch}, {g.regwr, g.memwr, g.mem2reg, g.branch});
      end
   endtask

   task automatic test_reset_flush();
      exp_t g;
      drive(32'h00221820, 32'h0, 32'd5, 32'd7);
      rst = 1'b0; flush = 1'b1;
      sb.push_back('{32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
      tick();
      g = sb.pop_front();
      n_cmp++; if ({me_alu_out, me_wr_reg, me_regwr, me_store_data} !== {g.alu, g.wr_reg, g.regwr, g.store}) begin
         n_bad++; $display("FAIL rst_over_add: got alu=%h wr=%0d rw=%b st=%h want zeros", me_alu_out, me_wr_reg, me_regwr, me_store_data);
      end
      rst = 1'b1; flush = 1'b1;
      drive(32'hAC220008, 32'h0, 32'h100, 32'hAB);
      sb.push_back('{32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
      tick();
      g = sb.pop_front();
      n_cmp++; if (me_memwr !== g.memwr) begin n_bad++; $display("FAIL flush_memwr: got %b want %b", me_memwr, g.memwr); end
      n_cmp++; if ({me_alu_out, me_store_data} !== {g.alu, g.store}) begin
         n_bad++; $display("FAIL flush_data: got %h/%h want %h/%h", me_alu_out, me_store_data, g.alu, g.store);
      end
      flush = 1'b0;
      sb.push_back('{32'h108, 5'd0, 32'hAB, 32'h20, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00});
      tick();
      g = sb.pop_front();
      n_cmp++; if ({me_memwr, me_alu_out} !== {g.memwr, g.alu}) begin
         n_bad++; $display("FAIL after_flush_sw: got %b/%h want %b/%h", me_memwr, me_alu_out, g.memwr, g.alu);
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0]  ops [0:19];
      logic [5:0]  fns [0:19];
      logic [31:0] i;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pc;
      exp_t        g;
      int          k;
      ops = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
              6'h00, 6'h08, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h04, 6'h05};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02,
              6'h03, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
      for (int n = 0; n < 60; n++) begin
         k  = $urandom_range(0, 19);
         i  = $urandom;
         i[31:26] = ops[k];
         if (ops[k] == 6'h00) i[5:0] = fns[k];
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
         pc = {$urandom, 2'b00} & 32'hFFFF_FFFC;
         drive(i, pc, a, b);
         sb.push_back(model(i, a, b, pc));
         tick();
         g = sb.pop_front();
         n_cmp++;
         if ({me_alu_out, me_wr_reg, me_store_data, me_branch_target, me_mem2reg,
              me_regwr, me_memwr, me_zero, me_branch} !==
             {g.alu, g.wr_reg, g.store, g.target, g.mem2reg, g.regwr, g.memwr, g.zero, g.branch}) begin
            n_bad++;
            $display("FAIL b2b[%0d] instr=%h: got alu=%h wr=%0d st=%h tg=%h c=%b%b%b%b br=%b want alu=%h wr=%0d st=%h tg=%h c=%b%b%b%b br=%b",
                     n, i, me_alu_out, me_wr_reg, me_store_data, me_branch_target,
                     me_mem2reg, me_regwr, me_memwr, me_zero, me_branch,
                     g.alu, g.wr_reg, g.store, g.target, g.mem2reg, g.regwr, g.memwr, g.zero, g.branch);
         end
      end
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0;
      instr = 32'h0; pc_plus4 = 32'h0; rs_data = 32'h0; rt_data = 32'h0;
      test_reset();
      test_add();
      test_lui();
      test_branch();
      test_mem();
      test_shift_compare();
      test_jump_bubble();
      test_reset_flush();
      test_back_to_back();
      if (sb.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
